mul_unit: RTL and testbench

MUL_UNIT -- requirements
Module: mul_unit

---
 rtl/mul_unit.sv | 78 +++++++
 tb/tb_mul_unit.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// mul_unit: radix-2 shift-add multiplier for MUL/MLA/UMULL/UMLAL/SMULL/SMLAL.
// Define MUL_UNIT_EARLY_TERM_EN to leave CALC once the remaining multiplier bits are zero.
module mul_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mul_ctl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [63:0] acc,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic [1:0]  nz
);
  typedef enum logic [1:0] {IDLE, CALC, ACC, DONE} state_t;
  state_t state, state_nx;
  logic [4:0]  cnt;
  logic [63:0] mcand, prod, acc_q, prod_s, sum, res;
  logic [31:0] mplr;
  logic [2:0]  op;
  logic        neg, sgn, accept, last;
  logic [1:0]  nz_d;
  assign sgn    = mul_ctl[2] & mul_ctl[1];
  assign accept = state == IDLE && start && mul_ctl[3] && (mul_ctl[2] || !mul_ctl[1]);
`ifdef MUL_UNIT_EARLY_TERM_EN
  assign last = mplr[31:1] == 31'h0;
`else
  assign last = cnt == 5'd31;
`endif
  assign busy = state == CALC || state == ACC;
  assign done = state == DONE;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = accept ? CALC : IDLE;
    else if (state == CALC) state_nx = last ? ACC : CALC;
    else if (state == ACC) state_nx = DONE;
    else state_nx = IDLE;
  end
  // Sign correction and accumulation happen together in ACC.
  always_comb begin
    prod_s = neg ? -prod : prod;
    sum    = prod_s + (op[0] ? (op[2] ? acc_q : {32'h0, acc_q[31:0]}) : 64'h0);
    res    = op[2] ? sum : {32'h0, sum[31:0]};
    nz_d   = op[2] ? {res[63], res == 64'h0} : {res[31], res[31:0] == 32'h0};
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt    <= 5'd0;
      mcand  <= 64'h0;
      mplr   <= 32'h0;
      prod   <= 64'h0;
      acc_q  <= 64'h0;
      op     <= 3'd0;
      neg    <= 1'b0;
      result <= 64'h0;
      nz     <= 2'b0;
    end else if (accept) begin
      cnt   <= 5'd0;
      mcand <= {32'h0, (sgn && a[31]) ? -a : a};
      mplr  <= (sgn && b[31]) ? -b : b;
      prod  <= 64'h0;
      acc_q <= acc;
      op    <= mul_ctl[2:0];
      neg   <= sgn && (a[31] ^ b[31]);
    end else if (state == CALC) begin
      prod  <= mplr[0] ? prod + mcand : prod;
      mcand <= mcand << 1;
      mplr  <= mplr >> 1;
      cnt   <= cnt + 5'd1;
    end else if (state == ACC) begin
      result <= res;
      nz     <= nz_d;
    end
endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: scoreboard bench for mul_unit; latency counts the start-sampling edge as edge 1.
module tb_mul_unit;
  logic        clk = 0, reset = 0, start = 0;
  logic [3:0]  mul_ctl = 0;
  logic [31:0] a = 0, b = 0;
  logic [63:0] acc = 0;
  logic        busy, done;
  logic [63:0] result;
  logic [1:0]  nz;
  int          n_cmp = 0, n_bad = 0;
  logic [65:0] sb[$];
  logic [3:0]  codes[6] = '{4'h8, 4'h9, 4'hC, 4'hD, 4'hE, 4'hF};
  always #5 clk = ~clk;
  mul_unit dut (.clk(clk), .reset(reset), .start(start), .mul_ctl(mul_ctl), .a(a), .b(b),
                .acc(acc), .busy(busy), .done(done), .result(result), .nz(nz));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [65:0] model(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y, input logic [63:0] z);
    logic [63:0] p, r;
    p = (c[2:1] == 2'b11) ? $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}) : {32'h0, x} * {32'h0, y};
    r = c[2] ? p + (c[0] ? z : 64'h0) : {32'h0, p[31:0] + (c[0] ? z[31:0] : 32'h0)};
    return {c[2] ? {r[63], r == 64'h0} : {r[31], r[31:0] == 32'h0}, r};
  endfunction
  function automatic int exp_lat(input logic [3:0] c, input logic [31:0] y);
`ifdef MUL_UNIT_EARLY_TERM_EN
    logic [31:0] m;
    int n;
    m = (c[2:1] == 2'b11 && y[31]) ? -y : y;
    n = 1;
    for (int i = 1; i < 32; i++) if (m[i]) n = i + 1;
    return n + 2;
`else
    return (c[0] | y[0]) ? 34 : 34;
`endif
  endfunction
  task automatic collect(input int lat);
    int e;
    logic [65:0] x;
    e = 1;
    while (!done && e < 100) begin
      @(negedge clk);
      e++;
      if (!done) begin
        a = $urandom;
        b = $urandom;
        acc = {$urandom, $urandom};
      end
    end
    chk("latency", 64'(e), 64'(lat));
    x = sb.pop_front();
    chk("result", result, x[63:0]);
    chk("nz", 64'(nz), 64'(x[65:64]));
    @(negedge clk);
    chk("done_pulse", 64'(done), 64'h0);
    chk("busy_idle", 64'(busy), 64'h0);
  endtask
  task automatic run(input logic [3:0] c, input logic [31:0] x, input logic [31:0] y, input logic [63:0] z, input bit hold);
    @(negedge clk);
    mul_ctl = c; a = x; b = y; acc = z; start = 1;
    sb.push_back(model(c, x, y, z));
    @(negedge clk);
    chk("busy_start", 64'(busy), 64'h1);
    start = hold;
    if (!hold) mul_ctl = 4'($urandom);
    a = $urandom; b = $urandom; acc = {$urandom, $urandom};
    collect(exp_lat(c, y));
    start = 0;
  endtask
  task automatic no_accept(input logic [3:0] c);
    int seen;
    seen = 0;
    @(negedge clk);
    mul_ctl = c; start = 1;
    repeat (3) begin
      @(negedge clk);
      start = 0;
      seen += int'(busy | done);
    end
    chk("illegal_ignored", 64'(seen), 64'h0);
  endtask
  initial begin
    int extra;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_result", result, 64'h0);
    chk("rst_nz", 64'(nz), 64'h0);
    reset = 1;
    run(4'hC, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0, 0);
    chk("umull_exact", result, 64'hFFFFFFFE00000001);
    run(4'hF, 32'hFFFFFFFE, 32'd3, 64'h6, 0);
    run(4'h9, 32'h10000, 32'h10000, 64'h5, 0);
    run(4'h8, 32'd7, 32'd1, 64'hFFFF, 0);
    run(4'hE, 32'h80000000, 32'h80000000, 64'h0, 0);
    run(4'hE, 32'h80000000, 32'd1, 64'h0, 0);
    run(4'hD, 32'h12345678, 32'h0, 64'hFFFFFFFFFFFFFFFF, 0);
    run(4'h8, 32'hFFFFFFFF, 32'h2, 64'h0, 0);
    for (int i = 0; i < 10; i++)
      run(codes[$urandom_range(0, 5)], $urandom, $urandom, {$urandom, $urandom}, 0);
    @(negedge clk);
    mul_ctl = 4'hC; a = 32'hDEADBEEF; b = 32'hFFFFFFFF; start = 1;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    reset = 0;
    #1;
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_done", 64'(done), 64'h0);
    chk("midrst_result", result, 64'h0);
    chk("midrst_nz", 64'(nz), 64'h0);
    @(negedge clk);
    reset = 1;
    extra = 0;
    repeat (2) begin
      @(negedge clk);
      extra += int'(busy | done);
    end
    chk("no_done_after_rst", 64'(extra), 64'h0);
    run(4'hD, 32'h89ABCDEF, 32'h13579BDF, 64'h0123456789ABCDEF, 0);
    no_accept(4'b0000);
    no_accept(4'b1010);
    no_accept(4'b1011);
    run(4'hE, 32'hFFFFFFF9, 32'd9, 64'h0, 1);
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      extra += int'(done | busy);
    end
    chk("held_start_extra", 64'(extra), 64'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
